// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter sharing one UART byte transmitter.
// Define UART_ARB_TIMEOUT_EN to force release of an idle grant holder.
module uart_tx_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] req0_data,
   input  logic       req0_valid,
   input  logic       req0_last,
   output logic       req0_ready,
   input  logic [7:0] req1_data,
   input  logic       req1_valid,
   input  logic       req1_last,
   output logic       req1_ready,
   output logic [7:0] uart_data,
   output logic       uart_valid,
   input  logic       uart_ready,
   output logic [1:0] grant,
   output logic       timeout_flag
);

   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 2");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic       rr_q, rr_d;
   logic       uvalid_q, uvalid_d;
   logic [7:0] udata_q, udata_d;
   logic [1:0] grant_q, grant_d;
   logic       out_free;
   logic       acc0, acc1;

   // Output slot can take a byte when empty or draining this cycle
   assign out_free   = !uvalid_q || uart_ready;
   assign req0_ready = (state_q == OWN0) && out_free;
   assign req1_ready = (state_q == OWN1) && out_free;
   assign acc0       = req0_valid && req0_ready;
   assign acc1       = req1_valid && req1_ready;

`ifdef UART_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          flag_q;
   logic          own_valid;
   logic          to_fire;

   assign own_valid = (state_q == OWN1) ? req1_valid : req0_valid;
   assign to_fire   = (state_q != IDLE) && !own_valid
                    && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (state_q == IDLE || acc0 || acc1 || to_fire) begin
         cnt_d = '0;
      end else if (!own_valid) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         flag_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         flag_q <= flag_q | to_fire;
      end
   end

   assign timeout_flag = flag_q;
`else
   assign timeout_flag = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      rr_d     = rr_q;
      uvalid_d = uvalid_q;
      udata_d  = udata_q;
      if (uvalid_q && uart_ready) begin
         uvalid_d = 1'b0;
      end
      unique case (state_q)
         IDLE: begin
            if (req0_valid && (!req1_valid || !rr_q)) begin
               state_d = OWN0;
            end else if (req1_valid) begin
               state_d = OWN1;
            end
         end
         OWN0: begin
            if (acc0) begin
               udata_d  = req0_data;
               uvalid_d = 1'b1;
               if (req0_last) begin
                  state_d = IDLE;
                  rr_d    = 1'b1;
               end
            end
         end
         OWN1: begin
            if (acc1) begin
               udata_d  = req1_data;
               uvalid_d = 1'b1;
               if (req1_last) begin
                  state_d = IDLE;
                  rr_d    = 1'b0;
               end
            end
         end
         default: state_d = IDLE;
      endcase
`ifdef UART_ARB_TIMEOUT_EN
      if (to_fire) begin
         state_d = IDLE;
         rr_d    = (state_q == OWN0);
      end
`endif
   end

   assign grant_d = {state_d == OWN1, state_d == OWN0};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         rr_q     <= 1'b0;
         uvalid_q <= 1'b0;
         udata_q  <= 8'h00;
         grant_q  <= 2'b00;
      end else begin
         state_q  <= state_d;
         rr_q     <= rr_d;
         uvalid_q <= uvalid_d;
         udata_q  <= udata_d;
         grant_q  <= grant_d;
      end
   end

   assign uart_data  = udata_q;
   assign uart_valid = uvalid_q;
   assign grant      = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized + directed bench for uart_tx_arbiter against a
// packet-level reference model (byte queue, owner, round-robin pointer).
module tb_uart_tx_arbiter;

   localparam int TO = 8;

   typedef logic [7:0] bq_t[$];

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] rd[2];
   logic       rv[2];
   logic       rl[2];
   logic       rdy[2];
   logic [7:0] uart_data;
   logic       uart_valid;
   logic       uart_ready = 1'b0;
   logic [1:0] grant;
   logic       timeout_flag;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   bit mon_en = 0;
   bit rnd_ur = 0;

   // reference model state
   bq_t mq;
   int  m_own = 0;
   bit  m_rr = 0;
   int  m_cnt = 0;
   bit  m_flag = 0;
   bq_t log_b;
   int  log_c[$];

   uart_tx_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk),
      .rst(rst),
      .req0_data(rd[0]),
      .req0_valid(rv[0]),
      .req0_last(rl[0]),
      .req0_ready(rdy[0]),
      .req1_data(rd[1]),
      .req1_valid(rv[1]),
      .req1_last(rl[1]),
      .req1_ready(rdy[1]),
      .uart_data(uart_data),
      .uart_valid(uart_valid),
      .uart_ready(uart_ready),
      .grant(grant),
      .timeout_flag(timeout_flag)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)",
                  tag, got, exp, cyc);
      end
   endtask

   function automatic logic [1:0] enc(input int own);
      return (own == 1) ? 2'b01 : (own == 2) ? 2'b10 : 2'b00;
   endfunction

   // Model: bytes accepted from requesters must leave the UART in order;
   // the owner follows packet-locked round-robin.
   always @(negedge clk) begin
      bit acc[2];
      int k;
      cyc++;
      if (mon_en) begin
         chk("grant", grant, enc(m_own));
         chk("rdy0", rdy[0], m_own == 1 && (mq.size() == 0 || uart_ready));
         chk("rdy1", rdy[1], m_own == 2 && (mq.size() == 0 || uart_ready));
         chk("uvalid", uart_valid, mq.size() != 0);
         if (mq.size() != 0) chk("udata", uart_data, mq[0]);
         chk("tflag", timeout_flag, m_flag);
      end
      if (rst) begin
         mq.delete();
         m_own = 0; m_rr = 0; m_cnt = 0; m_flag = 0;
      end else begin
         acc[0] = rv[0] && rdy[0];
         acc[1] = rv[1] && rdy[1];
         if (uart_valid && uart_ready) begin
            if (mq.size() != 0) void'(mq.pop_front());
            log_b.push_back(uart_data);
            log_c.push_back(cyc);
         end
         for (int i = 0; i < 2; i++) if (acc[i]) mq.push_back(rd[i]);
         if (m_own == 0) begin
            if (rv[0] && rv[1]) m_own = m_rr ? 2 : 1;
            else if (rv[0]) m_own = 1;
            else if (rv[1]) m_own = 2;
         end else begin
            k = m_own - 1;
            if (acc[k] && rl[k]) begin
               m_own = 0; m_rr = (k == 0); m_cnt = 0;
            end
`ifdef UART_ARB_TIMEOUT_EN
            else if (!rv[k]) begin
               if (m_cnt == TO - 1) begin
                  m_own = 0; m_rr = (k == 0); m_flag = 1; m_cnt = 0;
               end else m_cnt++;
            end else if (acc[k]) m_cnt = 0;
`endif
         end
      end
   end

   initial forever begin
      @(posedge clk);
      #1;
      if (rnd_ur) uart_ready = ($urandom % 4) != 0;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_hs(input int k);
      bit hs = 0;
      int n = 0;
      do begin
         @(negedge clk);
         hs = rv[k] && rdy[k];
         step();
         n++;
      end while (!hs && n < 300);
      chk("hs_to", hs, 1);
   endtask

   task automatic send(input int k, input bq_t b, input int maxgap);
      for (int i = 0; i < b.size(); i++) begin
         rd[k] = b[i];
         rl[k] = (i == b.size() - 1);
         rv[k] = 1'b1;
         wait_hs(k);
         rv[k] = 1'b0;
         rl[k] = 1'b0;
         if (maxgap > 0) repeat ($urandom_range(maxgap, 0)) step();
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         rv[i] = 1'b0; rl[i] = 1'b0; rd[i] = 8'h00;
      end
      repeat (2) step();
      rst = 1'b0;
      log_b.delete();
      log_c.delete();
      mon_en = 1;
   endtask

   task automatic chk_log(input string tag, input bq_t exp);
      chk({tag, "_n"}, log_b.size(), exp.size());
      for (int i = 0; i < exp.size() && i < log_b.size(); i++)
         chk(tag, log_b[i], exp[i]);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bq_t p0, p1;
      // reset values
      do_reset();
      chk("rst_uv", uart_valid, 0);
      chk("rst_ud", uart_data, 8'h00);
      chk("rst_gnt", grant, 2'b00);
      chk("rst_tf", timeout_flag, 0);

      // single 3-byte packet, back-to-back
      uart_ready = 1'b1;
      send(0, '{8'h41, 8'h42, 8'h43}, 0);
      chk("s1_gnt", grant, 2'b00);
      step();
      chk_log("s1_log", '{8'h41, 8'h42, 8'h43});
      if (log_c.size() == 3) begin
         chk("s1_b2b1", log_c[1] - log_c[0], 1);
         chk("s1_b2b2", log_c[2] - log_c[1], 1);
      end

      // simultaneous requests: req0 first, then req1, then req0 again
      do_reset();
      uart_ready = 1'b1;
      fork
         send(0, '{8'h10, 8'h11}, 0);
         send(1, '{8'h20, 8'h21}, 0);
      join
      repeat (2) step();
      fork
         send(0, '{8'h30}, 0);
         send(1, '{8'h40}, 0);
      join
      repeat (2) step();
      chk_log("s2_log", '{8'h10, 8'h11, 8'h20, 8'h21, 8'h30, 8'h40});

      // stall with 55 held
      do_reset();
      uart_ready = 1'b0;
      rd[0] = 8'h55; rl[0] = 1'b0; rv[0] = 1'b1;
      wait_hs(0);
      rd[0] = 8'h56; rl[0] = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk("s3_uv", uart_valid, 1);
         chk("s3_ud", uart_data, 8'h55);
         chk("s3_rdy", rdy[0], 0);
         step();
      end
      uart_ready = 1'b1;
      #1;
      chk("s3_rdy_up", rdy[0], 1);
      step();
      rv[0] = 1'b0; rl[0] = 1'b0;
      chk("s3_ud2", uart_data, 8'h56);
      chk("s3_uv2", uart_valid, 1);
      chk_log("s3_log", '{8'h55});
      repeat (2) step();

      // mid-packet valid drop keeps the grant
      do_reset();
      uart_ready = 1'b1;
      rd[1] = 8'h7E; rl[1] = 1'b0; rv[1] = 1'b1;
      wait_hs(1);
      rv[1] = 1'b0;
      rd[0] = 8'h99; rl[0] = 1'b1; rv[0] = 1'b1;
`ifdef UART_ARB_TIMEOUT_EN
      for (int i = 1; i <= 9; i++) begin
         step();
         chk("s4_gnt", grant, (i < 8) ? 2'b10 : (i == 8) ? 2'b00 : 2'b01);
         chk("s4_tf", timeout_flag, i >= 8);
      end
      wait_hs(0);
      rv[0] = 1'b0; rl[0] = 1'b0;
`else
      for (int i = 1; i <= 20; i++) begin
         step();
         chk("s4_gnt", grant, 2'b10);
         chk("s4_rdy0", rdy[0], 0);
      end
      rd[1] = 8'h7F; rl[1] = 1'b1; rv[1] = 1'b1;
      wait_hs(1);
      rv[1] = 1'b0; rl[1] = 1'b0;
      wait_hs(0);
      rv[0] = 1'b0; rl[0] = 1'b0;
      repeat (2) step();
      chk_log("s4_log", '{8'h7E, 8'h7F, 8'h99});
`endif
      repeat (2) step();

      // reset mid-packet
      do_reset();
      uart_ready = 1'b0;
      rd[0] = 8'hA5; rl[0] = 1'b0; rv[0] = 1'b1;
      wait_hs(0);
      chk("s5_uv_pre", uart_valid, 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("s5_uv", uart_valid, 0);
      chk("s5_gnt", grant, 2'b00);
      chk("s5_rdy0", rdy[0], 0);
      chk("s5_rdy1", rdy[1], 0);
      rd[0] = 8'hB0; rl[0] = 1'b1;
      rd[1] = 8'hC0; rl[1] = 1'b1; rv[1] = 1'b1;
      uart_ready = 1'b1;
      step();
      chk("s5_gnt2", grant, 2'b01);
      wait_hs(0);
      rv[0] = 1'b0; rl[0] = 1'b0;
      wait_hs(1);
      rv[1] = 1'b0; rl[1] = 1'b0;
      repeat (2) step();

      // randomized traffic with random UART back-pressure
      do_reset();
      rnd_ur = 1;
      for (int it = 0; it < 40; it++) begin
         bit e0, e1;
         p0.delete();
         p1.delete();
         e0 = ($urandom % 4) != 0;
         e1 = ($urandom % 4) != 0;
         repeat ($urandom_range(4, 1)) p0.push_back(8'($urandom));
         repeat ($urandom_range(4, 1)) p1.push_back(8'($urandom));
         fork
            begin if (e0) send(0, p0, 2); end
            begin if (e1) send(1, p1, 2); end
         join
         repeat ($urandom_range(2, 0)) step();
      end
      rnd_ur = 0;
      uart_ready = 1'b1;
      repeat (3) step();
      chk("drain", uart_valid, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
